i2c_reg_arb: RTL



---
 rtl/i2c_reg_arb.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/i2c_reg_arb.sv
// rtl/i2c_reg_arb.sv - round-robin arbiter with per-requester lock between two I2C slave engines and the register file
// Optional lock-idle timeout is built when I2C_REG_ARB_TIMEOUT_EN is defined.
module i2c_reg_arb #(
  parameter int AW      = 8,
  parameter int DW      = 8,
  parameter int RD_LAT  = 1,
  parameter int TMO_CYC = 65535
) (
  input  logic          SYSCLK,
  input  logic          RESET,
  input  logic          REQ0,
  input  logic          REQ1,
  input  logic          LOCK0,
  input  logic          LOCK1,
  input  logic          WE0,
  input  logic          WE1,
  input  logic [AW-1:0] ADDR0,
  input  logic [AW-1:0] ADDR1,
  input  logic [DW-1:0] WDATA0,
  input  logic [DW-1:0] WDATA1,
  output logic          ACK0,
  output logic          ACK1,
  output logic [DW-1:0] RDATA0,
  output logic [DW-1:0] RDATA1,
  output logic          REG_SEL,
  output logic          REG_WE,
  output logic [AW-1:0] REG_ADDR,
  output logic [DW-1:0] REG_WDATA,
  input  logic [DW-1:0] REG_RDATA,
  output logic          OWNER,
  output logic          BUSY,
  output logic          TMO_FLAG
);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;
  localparam logic [1:0] WAIT_LAST = 2'(RD_LAT - 1);

  logic [1:0]    state_q, state_d;
  logic [1:0]    wcnt_q, wcnt_d;
  logic          ptr_q, ptr_d;
  logic          lock_q, lock_d;
  logic          owner_q, owner_d;
  logic          we_q, we_d;
  logic          cap_lock_q, cap_lock_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [DW-1:0] rdata0_q, rdata0_d;
  logic [DW-1:0] rdata1_q, rdata1_d;
  logic          own_req, own_lock, tmo_hit, grant, win;

  // The lock always belongs to the last granted requester.
  assign own_req  = owner_q ? REQ1 : REQ0;
  assign own_lock = owner_q ? LOCK1 : LOCK0;

`ifdef I2C_REG_ARB_TIMEOUT_EN
  localparam logic [15:0] TMO_LAST = 16'(TMO_CYC - 1);
  logic [15:0] tcnt_q;
  logic        tmo_q, tmo_run;

  assign tmo_run = (state_q == IDLE) && lock_q && own_lock && !own_req;
  assign tmo_hit = tmo_run && (tcnt_q == TMO_LAST);

  always_ff @(posedge SYSCLK) begin
    if (RESET) begin
      tcnt_q <= '0;
      tmo_q  <= 1'b0;
    end else begin
      tcnt_q <= tmo_run ? tcnt_q + 16'd1 : '0;
      tmo_q  <= tmo_hit;
    end
  end

  assign TMO_FLAG = tmo_q;
`else
  assign tmo_hit  = 1'b0;
  assign TMO_FLAG = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    wcnt_d     = wcnt_q;
    ptr_d      = ptr_q;
    lock_d     = lock_q;
    owner_d    = owner_q;
    we_d       = we_q;
    cap_lock_d = cap_lock_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rdata0_d   = rdata0_q;
    rdata1_d   = rdata1_q;
    grant      = 1'b0;
    win        = 1'b0;
    case (state_q)
      IDLE: begin
        if (tmo_hit) begin
          lock_d = 1'b0;
          ptr_d  = ~owner_q;
        end else begin
          if (lock_q && own_lock) begin
            grant = own_req;
            win   = owner_q;
          end else begin
            lock_d = 1'b0;
            if (REQ0 && REQ1) begin
              grant = 1'b1;
              win   = ptr_q;
              ptr_d = ~ptr_q;
            end else begin
              grant = REQ0 | REQ1;
              win   = REQ1;
            end
          end
          if (grant) begin
            owner_d    = win;
            we_d       = win ? WE1 : WE0;
            addr_d     = win ? ADDR1 : ADDR0;
            wdata_d    = win ? WDATA1 : WDATA0;
            cap_lock_d = win ? LOCK1 : LOCK0;
            state_d    = ISSUE;
          end
        end
      end
      ISSUE: begin
        wcnt_d  = '0;
        state_d = we_q ? DONE : WAIT;
      end
      WAIT: begin
        if (wcnt_q == WAIT_LAST) begin
          if (owner_q) rdata1_d = REG_RDATA;
          else         rdata0_d = REG_RDATA;
          state_d = DONE;
        end else begin
          wcnt_d = wcnt_q + 2'd1;
        end
      end
      default: begin
        lock_d  = cap_lock_q;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge SYSCLK) begin
    if (RESET) begin
      state_q    <= IDLE;
      wcnt_q     <= '0;
      ptr_q      <= 1'b0;
      lock_q     <= 1'b0;
      owner_q    <= 1'b0;
      we_q       <= 1'b0;
      cap_lock_q <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata0_q   <= '0;
      rdata1_q   <= '0;
    end else begin
      state_q    <= state_d;
      wcnt_q     <= wcnt_d;
      ptr_q      <= ptr_d;
      lock_q     <= lock_d;
      owner_q    <= owner_d;
      we_q       <= we_d;
      cap_lock_q <= cap_lock_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rdata0_q   <= rdata0_d;
      rdata1_q   <= rdata1_d;
    end
  end

  assign REG_SEL   = (state_q == ISSUE);
  assign REG_WE    = REG_SEL & we_q;
  assign REG_ADDR  = addr_q;
  assign REG_WDATA = wdata_q;
  assign ACK0      = (state_q == DONE) && !owner_q;
  assign ACK1      = (state_q == DONE) && owner_q;
  assign RDATA0    = rdata0_q;
  assign RDATA1    = rdata1_q;
  assign OWNER     = owner_q;
  assign BUSY      = (state_q != IDLE);
endmodule
